axi_lite_sram_slave: RTL and testbench
======================================

Name: axi_lite_sram_slave

Overview:
- AXI-lite slave memory model: the responder end of the memory port that the IFU/WBU arbiter drives.
- Accepts read and write transactions on AR/R and AW/W/B with one outstanding read and one outstanding write.
- Backs them with an internal word-addressed SRAM array.
- Inserts a fixed or LFSR-pseudo-random response delay so initiators are exercised against variable latency.

Parameters:
ADDR_BASE 32'h8000_0000 byte address of word 0
DEPTH_WORDS 1024 number of 32-bit words in the array
RANDOM_DELAY 1 1: delay from LFSR; 0: delay = FIXED_DELAY
FIXED_DELAY 0 wait cycles when RANDOM_DELAY=0
DELAY_BITS 3 LFSR bits used for delay, giving a random range 0..2^DELAY_BITS-1
LFSR_SEED 8'hA5 LFSR reset value (must be nonzero)

Ports:
clk input 1 clock
rst input 1 asynchronous, active-high reset
araddr input 32 read address
arvalid input 1 read address valid
arready output 1 read address ready
rdata output 32 read data
rresp output 2 read response
rvalid output 1 read data valid
rready input 1 read data ready
awaddr input 32 write address
awvalid input 1 write address valid
awready output 1 write address ready
wdata input 32 write data
wstrb input 8 write strobe; bits [3:0] are byte enables, [7:4] ignored
wvalid input 1 write data valid
wready output 1 write data ready
bresp output 2 write response
bvalid output 1 write response valid
bready input 1 write response ready

Behaviour:
- Reset, asynchronous: both FSMs go to IDLE and LFSR = LFSR_SEED.
  - rvalid=0, bvalid=0, rdata=0, rresp=0, bresp=0.
  - Array contents are not reset.
- Ready signals:
  - arready = (rstate==R_IDLE); awready = !aw_held && wstate==W_IDLE; wready = !w_held && wstate==W_IDLE.
  - No ready depends on its valid. The initiator gates its valid on ready being high first, so arready/awready/wready are 1 in the cycle after reset deassertion.
- Address decode:
  - idx = (addr - ADDR_BASE) >> 2; addr[1:0] ignored.
  - In range if addr >= ADDR_BASE and idx < DEPTH_WORDS; otherwise the response is SLVERR (2'b10) and OKAY is 2'b00.
- Delay value D, sampled at handshake:
  - RANDOM_DELAY=1: D = lfsr[DELAY_BITS-1:0].
  - RANDOM_DELAY=0: D = FIXED_DELAY.
  - LFSR: 8-bit Fibonacci, taps 8,6,5,4, advances every cycle; it is shared by both FSMs.
- Read FSM (R_IDLE, R_WAIT, R_RESP):
  - R_IDLE: on arvalid&&arready, latch idx/range and load cnt=D, then go to R_WAIT.
  - R_WAIT: when cnt==0, register rdata = mem[idx] (or 0 if out of range) and rresp, assert rvalid, and go to R_RESP; else cnt--.
  - R_RESP: hold rvalid, rdata and rresp stable until rready; on rvalid&&rready, rvalid=0 and return to R_IDLE.
  - Latency: AR handshake at edge T, rvalid first high after edge T+1+D.
- Write FSM (W_IDLE, W_WAIT, W_RESP):
  - W_IDLE: AW and W are accepted independently, in the same or different cycles, into aw_held/w_held registers.
  - When both are held, or both handshake in the same cycle, load cnt=D and go to W_WAIT.
  - W_WAIT: when cnt==0 and in range, write mem[idx] bytes where wstrb[i]=1. Set bresp and bvalid, then go to W_RESP. Out of range: no write, bresp=SLVERR.
  - W_RESP: hold bvalid/bresp until bready; on handshake clear aw_held/w_held and return to W_IDLE.
- Simultaneous read and write:
  - Read and write proceed concurrently.
  - If the read data sample and the write commit hit the same idx in the same cycle, the read returns the pre-write value.
- A response held without ready is held indefinitely; there is no timeout.
- Reset asserted mid-transaction aborts it. Any pending write not yet committed is dropped, and no response is issued after reset.

Decomposition:
- Package axi_lite_pkg:
  - RESP_OKAY=2'b00, RESP_SLVERR=2'b10.
  - Read state encoding R_IDLE=0, R_WAIT=1, R_RESP=2.
  - Write state encoding W_IDLE=0, W_WAIT=1, W_RESP=2.
- Sub-module lfsr8 (clk, rst, seed parameter, 8-bit q output) is instantiated once.

Test Plan:
- Fixed-delay write then read: RANDOM_DELAY=0, FIXED_DELAY=2.
  - Stimulus: write 32'hDEADBEEF to 32'h8000_0010 with wstrb=8'h0F, then read the same address.
  - Required: bvalid 3 cycles after the AW/W handshake with bresp=0; rvalid 3 cycles after the AR handshake with rdata=32'hDEADBEEF and rresp=0.
- Byte strobes: write 32'h11223344 (wstrb=8'h0F), then write 32'hAABBCCDD with wstrb=8'h05.
  - Required: readback is 32'h11BB33DD.
- Split AW/W: awvalid at cycle 0, wvalid at cycle 3.
  - Required: awready drops after cycle 0; no bvalid before the W handshake; the write commits correctly.
- Out of range:
  - Read 32'h7FFF_FFFC → rresp=2'b10, rdata=0.
  - Write at 32'h8000_1000 (DEPTH_WORDS=1024) → bresp=2'b10 and the array is unchanged.
- Backpressure:
  - Hold rready=0 for 5 cycles after rvalid → rvalid and rdata stay stable and arready=0 throughout.
  - Release rready → arready=1 on the next cycle.
- Random delay and reset:
  - RANDOM_DELAY=1 with 200 back-to-back reads → every observed latency lies in 1..8 and the data matches the model.
  - Assert rst while in R_WAIT → rvalid=0 and arready=1 after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared constants for the AXI-lite SRAM responder.
// Response codes and read/write FSM encodings.
package axi_lite_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_RESP = 2'd2
  } rstate_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_WAIT = 2'd1,
    W_RESP = 2'd2
  } wstate_t;

endpackage

// File: rtl/lfsr8.sv
// 8-bit Fibonacci LFSR, taps 8,6,5,4.
// Free-running source of pseudo-random response delays.
module lfsr8 #(
  parameter logic [7:0] SEED = 8'hA5
) (
  input  logic       clk,
  input  logic       rst,
  output logic [7:0] q
);

  // shift left, feedback from taps 8,6,5,4
  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= SEED;
    else     q <= {q[6:0], q[7] ^ q[5] ^ q[4] ^ q[3]};
  end

endmodule

// File: rtl/axi_lite_sram_slave.sv
// AXI-lite responder backed by a word-addressed SRAM.
// One read and one write outstanding, variable latency.
module axi_lite_sram_slave
  import axi_lite_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE    = 32'h8000_0000,
  parameter int          DEPTH_WORDS  = 1024,
  parameter bit          RANDOM_DELAY = 1'b1,
  parameter int          FIXED_DELAY  = 0,
  parameter int          DELAY_BITS   = 3,
  parameter logic [7:0]  LFSR_SEED    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] araddr,
  input  logic        arvalid,
  output logic        arready,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rvalid,
  input  logic        rready,
  input  logic [31:0] awaddr,
  input  logic        awvalid,
  output logic        awready,
  input  logic [31:0] wdata,
  input  logic [7:0]  wstrb,
  input  logic        wvalid,
  output logic        wready,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready
);

  localparam int IDX_W =
    (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [7:0] DLY_MASK =
    8'((1 << DELAY_BITS) - 1);

  logic [31:0] mem [DEPTH_WORDS];

  logic [7:0] lfsr_q;
  logic [7:0] dly;

  lfsr8 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk (clk),
    .rst (rst),
    .q   (lfsr_q)
  );

  assign dly = RANDOM_DELAY ? (lfsr_q & DLY_MASK)
                            : 8'(FIXED_DELAY);

  logic unused_strb;
  assign unused_strb = ^wstrb[7:4];

  function automatic logic in_rng(input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return (a >= ADDR_BASE) &&
           ((off >> 2) < 32'(DEPTH_WORDS));
  endfunction

  function automatic logic [IDX_W-1:0] to_idx(
    input logic [31:0] a);
    logic [31:0] off;
    off = a - ADDR_BASE;
    return off[IDX_W+1:2];
  endfunction

  rstate_t          rstate, rnext;
  logic [IDX_W-1:0] r_idx;
  logic             r_ok;
  logic [7:0]       r_cnt;
  logic             ar_hs;

  assign arready = (rstate == R_IDLE);
  assign ar_hs   = arvalid && arready;

  // read next-state
  always_comb begin
    rnext = rstate;
    unique case (rstate)
      R_IDLE:  if (ar_hs) rnext = R_WAIT;
      R_WAIT:  if (r_cnt == 8'd0) rnext = R_RESP;
      R_RESP:  if (rready) rnext = R_IDLE;
      default: rnext = R_IDLE;
    endcase
  end

  // read state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rstate <= R_IDLE;
    else     rstate <= rnext;
  end

  // read datapath: latch request, count, sample array
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_idx  <= '0;
      r_ok   <= 1'b0;
      r_cnt  <= 8'd0;
      rdata  <= 32'd0;
      rresp  <= RESP_OKAY;
      rvalid <= 1'b0;
    end else begin
      if (ar_hs) begin
        r_idx <= to_idx(araddr);
        r_ok  <= in_rng(araddr);
        r_cnt <= dly;
      end
      if (rstate == R_WAIT) begin
        if (r_cnt == 8'd0) begin
          rdata  <= r_ok ? mem[r_idx] : 32'd0;
          rresp  <= r_ok ? RESP_OKAY : RESP_SLVERR;
          rvalid <= 1'b1;
        end else begin
          r_cnt <= r_cnt - 8'd1;
        end
      end
      if (rstate == R_RESP && rready) rvalid <= 1'b0;
    end
  end

  wstate_t          wstate, wnext;
  logic             aw_held, w_held;
  logic [IDX_W-1:0] w_idx;
  logic             w_ok;
  logic [31:0]      w_data;
  logic [3:0]       w_strb;
  logic [7:0]       w_cnt;
  logic             aw_hs, w_hs, w_both, w_commit;

  assign awready  = !aw_held && wstate == W_IDLE;
  assign wready   = !w_held && wstate == W_IDLE;
  assign aw_hs    = awvalid && awready;
  assign w_hs     = wvalid && wready;
  assign w_both   = (aw_held || aw_hs) && (w_held || w_hs);
  assign w_commit = (wstate == W_WAIT) && (w_cnt == 8'd0);

  // write next-state
  always_comb begin
    wnext = wstate;
    unique case (wstate)
      W_IDLE:  if (w_both) wnext = W_WAIT;
      W_WAIT:  if (w_cnt == 8'd0) wnext = W_RESP;
      W_RESP:  if (bready) wnext = W_IDLE;
      default: wnext = W_IDLE;
    endcase
  end

  // write state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) wstate <= W_IDLE;
    else     wstate <= wnext;
  end

  // write datapath: hold AW/W, count, respond
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      w_idx   <= '0;
      w_ok    <= 1'b0;
      w_data  <= 32'd0;
      w_strb  <= 4'd0;
      w_cnt   <= 8'd0;
      bresp   <= RESP_OKAY;
      bvalid  <= 1'b0;
    end else begin
      if (aw_hs) begin
        aw_held <= 1'b1;
        w_idx   <= to_idx(awaddr);
        w_ok    <= in_rng(awaddr);
      end
      if (w_hs) begin
        w_held <= 1'b1;
        w_data <= wdata;
        w_strb <= wstrb[3:0];
      end
      if (wstate == W_IDLE && w_both) w_cnt <= dly;
      if (wstate == W_WAIT) begin
        if (w_cnt == 8'd0) begin
          bresp  <= w_ok ? RESP_OKAY : RESP_SLVERR;
          bvalid <= 1'b1;
        end else begin
          w_cnt <= w_cnt - 8'd1;
        end
      end
      if (wstate == W_RESP && bready) begin
        bvalid  <= 1'b0;
        aw_held <= 1'b0;
        w_held  <= 1'b0;
      end
    end
  end

  // byte-masked commit; a same-cycle read sees the old word
  always_ff @(posedge clk) begin
    if (w_commit && w_ok) begin
      for (int b = 0; b < 4; b++) begin
        if (w_strb[b]) mem[w_idx][8*b +: 8] <= w_data[8*b +: 8];
      end
    end
  end

endmodule

// File: tb/tb_axi_lite_sram_slave.sv
// Directed bench for axi_lite_sram_slave.
// Fixed-delay instance for timing, random-delay instance for latency spread.
module tb_axi_lite_sram_slave;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        sel = 1'b0;
  logic [31:0] araddr = '0, awaddr = '0, wdata = '0;
  logic [7:0]  wstrb = '0;
  logic        arvalid = 0, rready = 0, awvalid = 0;
  logic        wvalid = 0, bready = 0;

  logic        f_arready, f_rvalid, f_awready, f_wready, f_bvalid;
  logic [31:0] f_rdata;
  logic [1:0]  f_rresp, f_bresp;
  logic        g_arready, g_rvalid, g_awready, g_wready, g_bvalid;
  logic [31:0] g_rdata;
  logic [1:0]  g_rresp, g_bresp;

  logic f_arvalid, f_rready, f_awvalid, f_wvalid, f_bready;
  logic g_arvalid, g_rready, g_awvalid, g_wvalid, g_bready;
  assign f_arvalid = arvalid & ~sel;
  assign f_rready  = rready  & ~sel;
  assign f_awvalid = awvalid & ~sel;
  assign f_wvalid  = wvalid  & ~sel;
  assign f_bready  = bready  & ~sel;
  assign g_arvalid = arvalid & sel;
  assign g_rready  = rready  & sel;
  assign g_awvalid = awvalid & sel;
  assign g_wvalid  = wvalid  & sel;
  assign g_bready  = bready  & sel;

  logic        m_arready, m_rvalid, m_awready, m_wready, m_bvalid;
  logic [31:0] m_rdata;
  logic [1:0]  m_rresp, m_bresp;
  assign m_arready = sel ? g_arready : f_arready;
  assign m_rvalid  = sel ? g_rvalid  : f_rvalid;
  assign m_rdata   = sel ? g_rdata   : f_rdata;
  assign m_rresp   = sel ? g_rresp   : f_rresp;
  assign m_awready = sel ? g_awready : f_awready;
  assign m_wready  = sel ? g_wready  : f_wready;
  assign m_bvalid  = sel ? g_bvalid  : f_bvalid;
  assign m_bresp   = sel ? g_bresp   : f_bresp;

  axi_lite_sram_slave #(
    .RANDOM_DELAY(1'b0), .FIXED_DELAY(2)
  ) dut_f (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(f_arvalid), .arready(f_arready),
    .rdata(f_rdata), .rresp(f_rresp), .rvalid(f_rvalid),
    .rready(f_rready),
    .awaddr(awaddr), .awvalid(f_awvalid), .awready(f_awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(f_wvalid),
    .wready(f_wready),
    .bresp(f_bresp), .bvalid(f_bvalid), .bready(f_bready)
  );

  axi_lite_sram_slave #(
    .RANDOM_DELAY(1'b1)
  ) dut_g (
    .clk(clk), .rst(rst),
    .araddr(araddr), .arvalid(g_arvalid), .arready(g_arready),
    .rdata(g_rdata), .rresp(g_rresp), .rvalid(g_rvalid),
    .rready(g_rready),
    .awaddr(awaddr), .awvalid(g_awvalid), .awready(g_awready),
    .wdata(wdata), .wstrb(wstrb), .wvalid(g_wvalid),
    .wready(g_wready),
    .bresp(g_bresp), .bvalid(g_bvalid), .bready(g_bready)
  );

  int ncmp = 0;
  int nfail = 0;

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tmo(input string tag);
    ncmp++;
    nfail++;
    $error("FAIL %s: timeout waiting on DUT", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d,
                          input logic [7:0] s, output int lat,
                          output logic [1:0] resp);
    logic aok, wok;
    int n;
    awaddr = a; wdata = d; wstrb = s;
    awvalid = 1; wvalid = 1; bready = 1;
    n = 0;
    while ((awvalid || wvalid) && n < 50) begin
      aok = m_awready;
      wok = m_wready;
      tick();
      if (aok) awvalid = 0;
      if (wok) wvalid = 0;
      n++;
    end
    if (awvalid || wvalid) tmo("wr_accept");
    awvalid = 0; wvalid = 0;
    lat = 0;
    while (!m_bvalid && lat < 50) begin
      tick();
      lat++;
    end
    if (!m_bvalid) tmo("wr_bvalid");
    resp = m_bresp;
    tick();
    bready = 0;
  endtask

  task automatic do_read(input logic [31:0] a, output int lat,
                         output logic [31:0] d,
                         output logic [1:0] resp);
    logic ok;
    int n;
    araddr = a; arvalid = 1; rready = 1;
    n = 0;
    while (arvalid && n < 50) begin
      ok = m_arready;
      tick();
      if (ok) arvalid = 0;
      n++;
    end
    if (arvalid) tmo("rd_accept");
    arvalid = 0;
    lat = 0;
    while (!m_rvalid && lat < 50) begin
      tick();
      lat++;
    end
    if (!m_rvalid) tmo("rd_rvalid");
    d = m_rdata;
    resp = m_rresp;
    tick();
    rready = 0;
  endtask

  logic [31:0] model [16];

  initial begin
    int lat, n, lat0;
    logic [31:0] d, held;
    logic [1:0] r;
    logic varied;

    #22 rst = 0;
    tick();
    check("rst_rvalid", {31'd0, f_rvalid}, 0);
    check("rst_bvalid", {31'd0, f_bvalid}, 0);
    check("rst_rdata", f_rdata, 0);
    check("rst_rresp", {30'd0, f_rresp}, 0);
    check("rst_bresp", {30'd0, f_bresp}, 0);
    check("rst_rdy", {29'd0, f_arready, f_awready, f_wready}, 7);
    check("rst_g_rvalid", {31'd0, g_rvalid}, 0);

    do_write(32'h8000_0010, 32'hDEADBEEF, 8'h0F, lat, r);
    check("fix_wr_lat", lat, 3);
    check("fix_wr_resp", {30'd0, r}, 0);
    do_read(32'h8000_0010, lat, d, r);
    check("fix_rd_lat", lat, 3);
    check("fix_rd_data", d, 32'hDEADBEEF);
    check("fix_rd_resp", {30'd0, r}, 0);

    do_write(32'h8000_0020, 32'h11223344, 8'h0F, lat, r);
    do_write(32'h8000_0020, 32'hAABBCCDD, 8'h05, lat, r);
    do_read(32'h8000_0020, lat, d, r);
    check("strb_data", d, 32'h11BB33DD);

    awaddr = 32'h8000_0030; awvalid = 1; bready = 1;
    tick();
    awvalid = 0;
    check("split_awready", {31'd0, m_awready}, 0);
    for (int i = 0; i < 3; i++) begin
      check("split_no_b", {31'd0, m_bvalid}, 0);
      tick();
    end
    check("split_wready", {31'd0, m_wready}, 1);
    wdata = 32'hCAFEF00D; wstrb = 8'hFF; wvalid = 1;
    tick();
    wvalid = 0;
    lat = 0;
    while (!m_bvalid && lat < 50) begin
      tick();
      lat++;
    end
    if (!m_bvalid) tmo("split_b");
    check("split_lat", lat, 3);
    check("split_bresp", {30'd0, m_bresp}, 0);
    tick();
    bready = 0;
    do_read(32'h8000_0030, lat, d, r);
    check("split_data", d, 32'hCAFEF00D);

    do_read(32'h7FFF_FFFC, lat, d, r);
    check("oor_rd_resp", {30'd0, r}, 2);
    check("oor_rd_data", d, 0);
    do_write(32'h8000_0000, 32'h01020304, 8'h0F, lat, r);
    do_write(32'h8000_1000, 32'hFFFFFFFF, 8'h0F, lat, r);
    check("oor_wr_resp", {30'd0, r}, 2);
    do_read(32'h8000_0000, lat, d, r);
    check("oor_wr_nochg", d, 32'h01020304);
    do_read(32'h8000_1000, lat, d, r);
    check("oor_rd2_resp", {30'd0, r}, 2);
    do_write(32'h8000_0FFC, 32'h5A5A0FF0, 8'h0F, lat, r);
    check("last_wr_resp", {30'd0, r}, 0);
    do_read(32'h8000_0FFC, lat, d, r);
    check("last_rd_data", d, 32'h5A5A0FF0);

    araddr = 32'h8000_0010; arvalid = 1; rready = 0;
    tick();
    arvalid = 0;
    n = 0;
    while (!m_rvalid && n < 50) begin
      tick();
      n++;
    end
    if (!m_rvalid) tmo("bp_rvalid");
    held = m_rdata;
    check("bp_data", held, 32'hDEADBEEF);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("bp_rvalid", {31'd0, m_rvalid}, 1);
      check("bp_rdata", m_rdata, held);
      check("bp_arready", {31'd0, m_arready}, 0);
    end
    rready = 1;
    tick();
    rready = 0;
    check("bp_rel_rvalid", {31'd0, m_rvalid}, 0);
    check("bp_rel_arready", {31'd0, m_arready}, 1);

    araddr = 32'h8000_0010; arvalid = 1;
    awaddr = 32'h8000_0010; awvalid = 1;
    tick();
    arvalid = 0; awvalid = 0;
    rst = 1;
    tick();
    rst = 0;
    tick();
    check("rstw_rvalid", {31'd0, m_rvalid}, 0);
    check("rstw_arready", {31'd0, m_arready}, 1);
    check("rstw_awready", {31'd0, m_awready}, 1);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("rstw_no_resp", {30'd0, m_rvalid, m_bvalid}, 0);
    end
    do_read(32'h8000_0010, lat, d, r);
    check("rstw_readback", d, 32'hDEADBEEF);

    sel = 1;
    tick();
    for (int i = 0; i < 16; i++) begin
      model[i] = 32'h1000_0000 + 32'(i) * 32'h0101_0101;
      do_write(32'h8000_0100 + 32'(4 * i), model[i], 8'h0F, lat, r);
      check("rnd_wr_lat", {31'd0, lat >= 1 && lat <= 8}, 1);
    end
    varied = 0;
    lat0 = -1;
    for (int i = 0; i < 200; i++) begin
      n = (i * 7) % 16;
      do_read(32'h8000_0100 + 32'(4 * n), lat, d, r);
      check("rnd_rd_lat", {31'd0, lat >= 1 && lat <= 8}, 1);
      check("rnd_rd_data", d, model[n]);
      if (lat0 >= 0 && lat != lat0) varied = 1;
      lat0 = lat;
    end
    check("rnd_lat_varies", {31'd0, varied}, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             ncmp, nfail);
    $finish;
  end

endmodule
